// File: rtl/led_pkg.sv
// led_pkg: shared mode/direction types and constants for the LED pattern controller
package led_pkg;
    localparam int RATE_W = 2;
    typedef enum logic [1:0] {MODE_ROTL, MODE_ROTR, MODE_PING, MODE_BLINK} mode_t;
    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;
    localparam logic COLOR_GREEN = 1'b0;
    localparam logic COLOR_BLUE  = 1'b1;
endpackage

// File: rtl/led_rate_prescaler.sv
// led_rate_prescaler: counts clocks and pulses tick once per selected period
module led_rate_prescaler
    import led_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int R0 = 3,
    parameter int R1 = 10,
    parameter int R2 = 100,
    parameter int R3 = 5000
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [RATE_W-1:0] rate,
    input  logic              en,
    input  logic              clear,
    output logic              tick
);
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] last;

    // last count value of the selected period; >= compare lets a shorter period take effect at once
    always_comb last = (rate == RATE_W'(0)) ? CNT_WIDTH'(R0 - 1) :
                       (rate == RATE_W'(1)) ? CNT_WIDTH'(R1 - 1) :
                       (rate == RATE_W'(2)) ? CNT_WIDTH'(R2 - 1) : CNT_WIDTH'(R3 - 1);

    assign tick = en & (cnt >= last);

    // restart on clear or tick, otherwise count only while enabled
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_WIDTH'(1);
    end
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: rate-ticked LED pattern generator with colour bank routing; LED_PWM_DIM_EN adds i_duty bank dimming
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int N_LEDS    = 4,
    parameter int CNT_WIDTH = 32,
    parameter int R0        = 3,
    parameter int R1        = 10,
    parameter int R2        = 100,
    parameter int R3        = 5000
) (
    input  logic              clock,
    input  logic              i_reset,
`ifdef LED_PWM_DIM_EN
    input  logic [3:0]        i_duty,
`endif
    input  logic [RATE_W-1:0] i_rate,
    input  logic [1:0]        i_mode,
    input  logic              i_en,
    input  logic              i_color,
    output logic [N_LEDS-1:0] o_led,
    output logic [N_LEDS-1:0] o_led_b,
    output logic [N_LEDS-1:0] o_led_g,
    output logic              o_tick
);
    logic [N_LEDS-1:0] pat, pat_nxt, init, adv, ping_pat;
    dir_t              dir, dir_nxt;
    mode_t             mode, mode_q;
    logic              change, tick, turn, go_left, on;

    assign mode   = mode_t'(i_mode);
    assign change = mode != mode_q;
    assign o_tick = tick;

    led_rate_prescaler #(
        .CNT_WIDTH(CNT_WIDTH), .R0(R0), .R1(R1), .R2(R2), .R3(R3)
    ) u_presc (
        .clock  (clock),
        .i_reset(i_reset),
        .rate   (i_rate),
        .en     (i_en),
        .clear  (change),
        .tick   (tick)
    );

    // next pattern: mode reload wins over a tick; ping-pong reverses on the tick that reaches an end
    always_comb begin
        init     = (mode == MODE_BLINK) ? {N_LEDS{1'b1}} : N_LEDS'(1);
        turn     = (dir == DIR_LEFT) ? pat[N_LEDS-1] : pat[0];
        go_left  = (dir == DIR_LEFT) ^ turn;
        ping_pat = (N_LEDS == 1) ? pat : go_left ? pat << 1 : pat >> 1;
        adv      = (mode_q == MODE_ROTL) ? (pat << 1) | (pat >> (N_LEDS - 1)) :
                   (mode_q == MODE_ROTR) ? (pat >> 1) | (pat << (N_LEDS - 1)) :
                   (mode_q == MODE_PING) ? ping_pat : ~pat;
        pat_nxt  = change ? init : tick ? adv : pat;
        dir_nxt  = change ? DIR_LEFT :
                   (tick && mode_q == MODE_PING) ? (go_left ? DIR_LEFT : DIR_RIGHT) : dir;
    end

    // pattern, direction and registered mode
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            pat    <= N_LEDS'(1);
            dir    <= DIR_LEFT;
            mode_q <= MODE_ROTL;
        end else begin
            pat    <= pat_nxt;
            dir    <= dir_nxt;
            mode_q <= mode;
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] p;

    // free-running dimming phase; banks are lit while p < i_duty
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset)
            p <= 4'd0;
        else
            p <= p + 4'd1;
    end

    assign on = p < i_duty;
`else
    assign on = 1'b1;
`endif

    assign o_led   = pat;
    assign o_led_b = (on && i_color == COLOR_BLUE)  ? pat : '0;
    assign o_led_g = (on && i_color == COLOR_GREEN) ? pat : '0;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed scoreboard bench for led_pattern_ctrl (default R0=3, R3=5000)
module tb_led_pattern_ctrl;
    logic       clock   = 1'b0;
    logic       i_reset = 1'b0;
    logic [1:0] i_rate  = 2'd0;
    logic [1:0] i_mode  = 2'd0;
    logic       i_en    = 1'b1;
    logic       i_color = 1'b0;
    logic [3:0] o_led, o_led_b, o_led_g;
    logic       o_tick;
`ifdef LED_PWM_DIM_EN
    logic [3:0] i_duty = 4'd0;
    int         lit;
`endif

    typedef struct {
        string      tag;
        logic [3:0] led;
        logic       tick;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] pp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    led_pattern_ctrl dut (
        .clock  (clock),
        .i_reset(i_reset),
`ifdef LED_PWM_DIM_EN
        .i_duty (i_duty),
`endif
        .i_rate (i_rate),
        .i_mode (i_mode),
        .i_en   (i_en),
        .i_color(i_color),
        .o_led  (o_led),
        .o_led_b(o_led_b),
        .o_led_g(o_led_g),
        .o_tick (o_tick)
    );

    always #5 clock = ~clock;

    task automatic push(input string tag, input logic [3:0] led, input logic tick);
        exp_t e;
        e.tag  = tag;
        e.led  = led;
        e.tick = tick;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t        e;
        logic [12:0] obs, want;
        e = sb.pop_front();
        vectors++;
`ifdef LED_PWM_DIM_EN
        obs  = {o_led, o_tick, 8'h00};
        want = {e.led, e.tick, 8'h00};
`else
        obs  = {o_led, o_tick, o_led_g, o_led_b};
        want = {e.led, e.tick, i_color ? 4'b0000 : e.led, i_color ? e.led : 4'b0000};
`endif
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: led/tick/g/b observed %b expected %b", e.tag, obs, want);
        end
    endtask

    task automatic check_now(input string tag, input logic [3:0] led, input logic tick);
        push(tag, led, tick);
        compare_front();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) compare_front();
        end
    endtask

    initial begin
        #12;
        check_now("reset", 4'b0001, 1'b0);
        @(negedge clock);
        i_reset = 1'b1;
        for (int j = 1; j <= 13; j++) push("rotl", 4'b0001 << ((j / 3) % 4), j % 3 == 2);
        run(13);

        @(negedge clock);
        i_mode = 2'd2;
        push("ping_reload", 4'b0001, 1'b0);
        for (int j = 1; j <= 23; j++) push("ping", pp[j / 3], j % 3 == 2);
        run(24);

        @(negedge clock);
        i_mode = 2'd3;
        push("blink_reload", 4'b1111, 1'b0);
        for (int j = 1; j <= 7; j++) push("blink", ((j / 3) % 2 == 1) ? 4'b0000 : 4'b1111, j % 3 == 2);
        run(8);

        @(negedge clock);
        i_mode = 2'd1;
        push("rotr_reload", 4'b0001, 1'b0);
        for (int j = 1; j <= 6; j++) push("rotr", (j < 3) ? 4'b0001 : (j < 6) ? 4'b1000 : 4'b0100, j % 3 == 2);
        run(7);

        @(negedge clock);
        i_rate = 2'd3;
        for (int j = 1; j <= 50; j++) push("slow_rate", 4'b0100, 1'b0);
        run(50);
        @(negedge clock);
        i_rate = 2'd0;
        #1;
        check_now("rate_shorten", 4'b0100, 1'b1);
        push("rate_adv", 4'b0010, 1'b0);
        push("rate_j1", 4'b0010, 1'b0);
        push("rate_j2", 4'b0010, 1'b1);
        push("rate_j3", 4'b0001, 1'b0);
        run(4);

        push("pre_freeze", 4'b0001, 1'b0);
        run(1);
        @(negedge clock);
        i_en = 1'b0;
        #1;
        check_now("en_off", 4'b0001, 1'b0);
        for (int j = 1; j <= 7; j++) push("frozen", 4'b0001, 1'b0);
        run(7);
        @(negedge clock);
        i_en = 1'b1;
        push("resume_tick", 4'b0001, 1'b1);
        push("resume_adv", 4'b1000, 1'b0);
        run(2);

        @(negedge clock);
        i_color = 1'b1;
        #1;
        check_now("color_blue", 4'b1000, 1'b0);
        push("mid_period", 4'b1000, 1'b0);
        run(1);

        @(negedge clock);
        #2;
        i_reset = 1'b0;
        i_mode  = 2'd0;
        #1;
        check_now("async_reset", 4'b0001, 1'b0);
        @(negedge clock);
        i_reset = 1'b1;
        push("post_rst1", 4'b0001, 1'b0);
        push("post_rst2", 4'b0001, 1'b1);
        push("post_rst3", 4'b0010, 1'b0);
        run(3);

`ifdef LED_PWM_DIM_EN
        @(negedge clock);
        i_color = 1'b0;
        i_duty  = 4'd4;
        lit     = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clock);
            #1;
            if (o_led_g !== 4'b0000) lit++;
        end
        vectors++;
        assert (lit == 4) else begin
            miscompares++;
            $error("FAIL pwm_duty4: lit cycles observed %0d expected 4", lit);
        end
        @(negedge clock);
        i_duty = 4'd0;
        lit    = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clock);
            #1;
            if (o_led_g !== 4'b0000) lit++;
        end
        vectors++;
        assert (lit == 0) else begin
            miscompares++;
            $error("FAIL pwm_duty0: lit cycles observed %0d expected 0", lit);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
